// File: rtl/reversal_mb_module.sv
// Lane reversal training stage of mainband init.
// Handshakes INIT/CLR/RESULT/DONE over sideband, retries once reversed.
module reversal_mb_module #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd8000,
  parameter logic [4:0]  PASS_THRESHOLD = 5'd8
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic        i_MBINIT_REPAIRCLK_end,
  input  logic [3:0]  i_RX_SbMessage,
  input  logic        i_msg_valid,
  input  logic [15:0] i_lanes_results,
  input  logic        i_falling_edge_busy,
  input  logic        i_pattern_done,
  output logic [3:0]  o_TX_SbMessage,
  output logic        o_tx_data_valid,
  output logic        o_pattern_en,
  output logic        o_lane_reversal,
  output logic        o_MBINIT_REVERSALMB_end,
  output logic        o_train_error
);

  typedef enum logic [3:0] {
    IDLE, SEND_INIT, WAIT_INIT,
    SEND_CLR, WAIT_CLR, PATTERN,
    SEND_RES, WAIT_RES, EVAL,
    SEND_DONE, WAIT_DONE, DONE,
    ERROR
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [15:0] cnt;
  logic [15:0] res;
  logic        rev;
  logic [4:0]  pop;
  logic        pass;
  logic [3:0]  exp_code;
  logic        hit;
  logic        counting;
  logic        timed_out;

  // Popcount of the captured lane results and pass decision.
  always_comb begin
    pop = '0;
    for (int i = 0; i < 16; i++) begin
      pop = pop + 5'(res[i]);
    end
    pass = (pop > PASS_THRESHOLD);
  end

  // Moore outputs plus the response each wait state is looking for.
  always_comb begin
    o_TX_SbMessage          = 4'd0;
    o_tx_data_valid         = 1'b0;
    o_pattern_en            = 1'b0;
    o_MBINIT_REVERSALMB_end = 1'b0;
    o_train_error           = 1'b0;
    exp_code                = 4'd0;
    counting                = 1'b0;
    unique case (state)
      SEND_INIT: begin
        o_TX_SbMessage  = 4'd1;
        o_tx_data_valid = 1'b1;
      end
      SEND_CLR: begin
        o_TX_SbMessage  = 4'd3;
        o_tx_data_valid = 1'b1;
      end
      SEND_RES: begin
        o_TX_SbMessage  = 4'd5;
        o_tx_data_valid = 1'b1;
      end
      SEND_DONE: begin
        o_TX_SbMessage  = 4'd7;
        o_tx_data_valid = 1'b1;
      end
      WAIT_INIT: begin
        exp_code = 4'd2;
        counting = 1'b1;
      end
      WAIT_CLR: begin
        exp_code = 4'd4;
        counting = 1'b1;
      end
      WAIT_RES: begin
        exp_code = 4'd6;
        counting = 1'b1;
      end
      WAIT_DONE: begin
        exp_code = 4'd8;
        counting = 1'b1;
      end
      PATTERN: begin
        o_pattern_en = 1'b1;
        counting     = 1'b1;
      end
      DONE:  o_MBINIT_REVERSALMB_end = 1'b1;
      ERROR: o_train_error = 1'b1;
      default: ;
    endcase
  end

  assign hit       = i_msg_valid && (i_RX_SbMessage == exp_code);
  assign timed_out = (cnt == TIMEOUT_CYCLES - 16'd1);
  assign o_lane_reversal = rev;

  // Next-state logic; a matching response beats a timeout.
  always_comb begin
    state_nx = state;
    if (!i_MBINIT_REPAIRCLK_end) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:      state_nx = SEND_INIT;
        SEND_INIT: if (i_falling_edge_busy) state_nx = WAIT_INIT;
        SEND_CLR:  if (i_falling_edge_busy) state_nx = WAIT_CLR;
        SEND_RES:  if (i_falling_edge_busy) state_nx = WAIT_RES;
        SEND_DONE: if (i_falling_edge_busy) state_nx = WAIT_DONE;
        WAIT_INIT: begin
          if (hit) state_nx = SEND_CLR;
          else if (timed_out) state_nx = ERROR;
        end
        WAIT_CLR: begin
          if (hit) state_nx = PATTERN;
          else if (timed_out) state_nx = ERROR;
        end
        PATTERN: begin
          if (i_pattern_done) state_nx = SEND_RES;
          else if (timed_out) state_nx = ERROR;
        end
        WAIT_RES: begin
          if (hit) state_nx = EVAL;
          else if (timed_out) state_nx = ERROR;
        end
        EVAL: begin
          if (pass) state_nx = SEND_DONE;
          else if (!rev) state_nx = SEND_CLR;
          else state_nx = ERROR;
        end
        WAIT_DONE: begin
          if (hit) state_nx = DONE;
          else if (timed_out) state_nx = ERROR;
        end
        DONE:    state_nx = DONE;
        ERROR:   state_nx = ERROR;
        default: state_nx = IDLE;
      endcase
    end
  end

  // State, timeout counter, captured results and reversal flag.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      res   <= '0;
      rev   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state_nx != state) cnt <= '0;
      else if (counting) cnt <= cnt + 16'd1;
      else cnt <= '0;
      if (state == WAIT_RES && state_nx == EVAL) res <= i_lanes_results;
      if (!i_MBINIT_REPAIRCLK_end) rev <= 1'b0;
      else if (state == EVAL && !pass && !rev) rev <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reversal_mb_module.sv
// Self-checking bench for reversal_mb_module.
// Directed scenarios plus randomized training runs against a transaction model.
module tb_reversal_mb_module;

  localparam logic [15:0] TMO = 16'd60;
  localparam logic [4:0]  THR = 5'd8;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  rx_msg;
  logic        msg_valid;
  logic [15:0] lanes;
  logic        busy;
  logic        pdone;
  logic [3:0]  tx_msg;
  logic        tx_valid;
  logic        pat_en;
  logic        lane_rev;
  logic        mb_end;
  logic        train_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  reversal_mb_module #(
    .TIMEOUT_CYCLES(TMO),
    .PASS_THRESHOLD(THR)
  ) dut (
    .CLK(CLK),
    .rst_n(rst_n),
    .i_MBINIT_REPAIRCLK_end(start),
    .i_RX_SbMessage(rx_msg),
    .i_msg_valid(msg_valid),
    .i_lanes_results(lanes),
    .i_falling_edge_busy(busy),
    .i_pattern_done(pdone),
    .o_TX_SbMessage(tx_msg),
    .o_tx_data_valid(tx_valid),
    .o_pattern_en(pat_en),
    .o_lane_reversal(lane_rev),
    .o_MBINIT_REVERSALMB_end(mb_end),
    .o_train_error(train_err)
  );

  function automatic logic [8:0] outs();
    return {tx_msg, tx_valid, pat_en, lane_rev, mb_end, train_err};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [15:0] mk_res();
    logic [15:0] r;
    int k;
    int mode;
    mode = int'($urandom_range(0, 2));
    if (mode == 0) return 16'($urandom);
    k = (mode == 1) ? int'(THR) + int'($urandom_range(0, 1))
                    : int'($urandom_range(0, 16));
    r = '0;
    while ($countones(r) < k) r[$urandom_range(0, 15)] = 1'b1;
    return r;
  endfunction

  task automatic wait_req(input logic [3:0] code, input string tag);
    int t;
    int hold;
    t = 0;
    while (!tx_valid && t < 40) begin
      tick();
      t++;
    end
    if (!tx_valid) begin
      check({tag, "_req_timeout"}, 32'd0, 32'd1);
      return;
    end
    check({tag, "_req_code"}, 32'(tx_msg), 32'(code));
    hold = int'($urandom_range(0, 2));
    for (int i = 0; i < hold; i++) begin
      msg_valid = 1'($urandom);
      rx_msg = code + 4'd1;
      tick();
      check({tag, "_req_hold"}, 32'({tx_valid, tx_msg}), 32'({1'b1, code}));
    end
    busy = 1'b1;
    msg_valid = 1'($urandom);
    rx_msg = code + 4'd1;
    tick();
    busy = 1'b0;
    msg_valid = 1'b0;
    rx_msg = 4'd0;
    check({tag, "_after_ack"}, 32'({tx_valid, tx_msg}), 32'd0);
  endtask

  task automatic give_resp(input logic [3:0] code, input logic [15:0] r,
                           input string tag);
    int n;
    logic [3:0] c;
    n = int'($urandom_range(0, 3));
    for (int i = 0; i < n; i++) begin
      c = 4'($urandom_range(0, 15));
      if (c == code) c = code ^ 4'd1;
      msg_valid = 1'b1;
      rx_msg = c;
      busy = 1'($urandom);
      pdone = 1'($urandom);
      lanes = 16'($urandom);
      tick();
      msg_valid = 1'b0;
      rx_msg = code;
      busy = 1'b0;
      pdone = 1'b0;
      tick();
      rx_msg = 4'd0;
    end
    check({tag, "_ignored"}, 32'({tx_valid, pat_en, train_err}), 32'd0);
    msg_valid = 1'b1;
    rx_msg = code;
    lanes = r;
    tick();
    msg_valid = 1'b0;
    rx_msg = 4'd0;
    lanes = 16'($urandom);
  endtask

  task automatic do_pattern(input string tag);
    int n;
    check({tag, "_pat_on"}, 32'(pat_en), 32'd1);
    n = int'($urandom_range(0, 4));
    for (int i = 0; i < n; i++) begin
      msg_valid = 1'($urandom);
      rx_msg = 4'($urandom);
      busy = 1'($urandom);
      tick();
      msg_valid = 1'b0;
      busy = 1'b0;
      rx_msg = 4'd0;
    end
    check({tag, "_pat_hold"}, 32'({pat_en, tx_valid}), 32'b10);
    pdone = 1'b1;
    tick();
    pdone = 1'b0;
    check({tag, "_pat_off"}, 32'(pat_en), 32'd0);
  endtask

  task automatic run_train(input logic [15:0] r1, input logic [15:0] r2,
                           input string tag);
    logic rev;
    logic fin;
    logic [15:0] r;
    rev = 1'b0;
    fin = 1'b0;
    start = 1'b1;
    wait_req(4'd1, {tag, "_init"});
    give_resp(4'd2, 16'($urandom), {tag, "_init"});
    while (!fin) begin
      wait_req(4'd3, {tag, "_clr"});
      check({tag, "_rev"}, 32'(lane_rev), 32'(rev));
      give_resp(4'd4, 16'($urandom), {tag, "_clr"});
      do_pattern(tag);
      wait_req(4'd5, {tag, "_res"});
      r = rev ? r2 : r1;
      give_resp(4'd6, r, {tag, "_res"});
      if ($countones(r) > int'(THR)) begin
        wait_req(4'd7, {tag, "_done"});
        give_resp(4'd8, 16'($urandom), {tag, "_done"});
        check({tag, "_end"}, 32'({mb_end, lane_rev, train_err}),
              32'({1'b1, rev, 1'b0}));
        tick();
        tick();
        check({tag, "_end_hold"}, 32'(outs()),
              32'({4'd0, 1'b0, 1'b0, rev, 1'b1, 1'b0}));
        fin = 1'b1;
      end else if (!rev) begin
        rev = 1'b1;
      end else begin
        tick();
        check({tag, "_err"}, 32'(outs()), 32'({7'd0, 1'b1, 1'b0, 1'b1}));
        tick();
        tick();
        check({tag, "_err_hold"}, 32'(train_err), 32'd1);
        fin = 1'b1;
      end
    end
    start = 1'b0;
    tick();
    check({tag, "_stop"}, 32'(outs()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    rx_msg = 4'd2;
    msg_valid = 1'b1;
    lanes = 16'hFFFF;
    busy = 1'b1;
    pdone = 1'b1;
    tick();
    tick();
    tick();
    check("reset_outs", 32'(outs()), 32'd0);
    start = 1'b0;
    msg_valid = 1'b0;
    busy = 1'b0;
    pdone = 1'b0;
    rx_msg = 4'd0;
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_no_start", 32'(outs()), 32'd0);

    run_train(16'hFFFF, 16'hFFFF, "nominal");
    run_train(16'h00FF, 16'hFF7F, "retry");
    run_train(16'h0001, 16'h0001, "dfail");

    start = 1'b1;
    wait_req(4'd1, "tmo");
    repeat (int'(TMO) - 1) tick();
    check("tmo_before", 32'({train_err, tx_valid}), 32'd0);
    tick();
    check("tmo_fire", 32'(outs()), 32'd1);
    start = 1'b0;
    tick();
    check("tmo_stop", 32'(outs()), 32'd0);

    start = 1'b1;
    wait_req(4'd1, "tmo_edge");
    repeat (int'(TMO) - 1) tick();
    msg_valid = 1'b1;
    rx_msg = 4'd2;
    tick();
    msg_valid = 1'b0;
    rx_msg = 4'd0;
    check("tmo_edge_win", 32'({train_err, tx_valid, tx_msg}),
          32'({1'b0, 1'b1, 4'd3}));
    wait_req(4'd3, "ign");
    msg_valid = 1'b1;
    rx_msg = 4'd6;
    tick();
    msg_valid = 1'b0;
    rx_msg = 4'd0;
    check("ign_code6", 32'({pat_en, tx_valid}), 32'd0);
    tick();
    check("ign_code6_hold", 32'({pat_en, tx_valid}), 32'd0);
    msg_valid = 1'b1;
    rx_msg = 4'd4;
    tick();
    msg_valid = 1'b0;
    rx_msg = 4'd0;
    check("ign_then_clr", 32'(pat_en), 32'd1);
    rst_n = 1'b0;
    tick();
    check("rst_in_pattern", 32'(outs()), 32'd0);
    rst_n = 1'b1;
    run_train(16'hFFFF, 16'h0000, "after_rst");

    start = 1'b1;
    wait_req(4'd1, "abort");
    give_resp(4'd2, 16'h0, "abort");
    wait_req(4'd3, "abort");
    give_resp(4'd4, 16'h0, "abort");
    do_pattern("abort");
    wait_req(4'd5, "abort");
    give_resp(4'd6, 16'h0003, "abort");
    wait_req(4'd3, "abort2");
    check("abort_rev", 32'(lane_rev), 32'd1);
    give_resp(4'd4, 16'h0, "abort2");
    do_pattern("abort2");
    wait_req(4'd5, "abort2");
    start = 1'b0;
    tick();
    check("abort_outs", 32'(outs()), 32'd0);
    run_train(16'hFFFF, 16'h0000, "restart");

    for (int k = 0; k < 25; k++) begin
      run_train(mk_res(), mk_res(), $sformatf("rnd%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reversal_mb_module.md
REVERSAL_MB_MODULE -- requirements
Module: reversal_mb_module

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd8000, the cycle limit for any single wait state.
REQ-002 SHALL have parameter PASS_THRESHOLD, default 5'd8; a lane result passes when its popcount exceeds this value.
REQ-003 SHALL have port CLK, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; synchronous and active-low.
REQ-005 SHALL have port i_MBINIT_REPAIRCLK_end, input, 1, the level start enable from the upstream REPAIRCLK stage.
REQ-006 SHALL have port i_RX_SbMessage, input, 4, the decoded received sideband message.
REQ-007 SHALL have port i_msg_valid, input, 1, a one-cycle strobe qualifying i_RX_SbMessage.
REQ-008 SHALL have port i_lanes_results, input, 16, per-lane pass bits; valid with a RESULT_RESP strobe.
REQ-009 SHALL have port i_falling_edge_busy, input, 1, a pulse indicating the sideband TX accepted the current message.
REQ-010 SHALL have port i_pattern_done, input, 1, a pulse from the pattern generator indicating the lane-ID pattern is complete.
REQ-011 SHALL have port o_TX_SbMessage, output, 4, the message to transmit.
REQ-012 SHALL have port o_tx_data_valid, output, 1, the request to the sideband TX.
REQ-013 SHALL have port o_pattern_en, output, 1, the level enable for the per-lane ID pattern.
REQ-014 SHALL have port o_lane_reversal, output, 1, the lane reversal applied to the mainband TX mapping.
REQ-015 SHALL have port o_MBINIT_REVERSALMB_end, output, 1, the completion level consumed by the downstream REPAIRMB stage.
REQ-016 SHALL have port o_train_error, output, 1, a sticky training failure flag.

Function
REQ-017 SHALL use the following message codes:
- 1 INIT_REQ, 2 INIT_RESP
- 3 CLR_REQ, 4 CLR_RESP
- 5 RESULT_REQ, 6 RESULT_RESP
- 7 DONE_REQ, 8 DONE_RESP
- 0 means no message.
REQ-018 SHALL implement the following states: IDLE, SEND_INIT, WAIT_INIT, SEND_CLR, WAIT_CLR, PATTERN, SEND_RES, WAIT_RES, EVAL, SEND_DONE, WAIT_DONE, DONE and ERROR.
REQ-019 SHALL move IDLE->SEND_INIT on the first cycle i_MBINIT_REPAIRCLK_end=1.
REQ-020 SHALL, in each SEND_x state, assert o_tx_data_valid=1 with o_TX_SbMessage held at that state's request code, and advance to WAIT_x on i_falling_edge_busy.
REQ-021 SHALL deassert o_tx_data_valid and drive o_TX_SbMessage=0 in the cycle after acceptance.
REQ-022 SHALL, in each WAIT_x state, advance only on i_msg_valid=1 with i_RX_SbMessage equal to the expected response code; other codes and strobes are ignored.
REQ-023 SHALL follow this transition order:
- WAIT_INIT->SEND_CLR
- WAIT_CLR->PATTERN
- PATTERN->SEND_RES on i_pattern_done
- WAIT_RES->EVAL, registering i_lanes_results in the same cycle
- WAIT_DONE->DONE
REQ-024 SHALL assert o_pattern_en=1 only while in PATTERN.
REQ-025 SHALL, in EVAL (one cycle), compute a 5-bit popcount of the registered results; PASS is popcount > PASS_THRESHOLD, compared as unsigned.
REQ-026 SHALL resolve EVAL as follows:
- PASS->SEND_DONE
- FAIL with o_lane_reversal=0: set o_lane_reversal=1 and go to SEND_CLR (single retry)
- FAIL with o_lane_reversal=1->ERROR
REQ-027 SHALL hold o_MBINIT_REVERSALMB_end=1 in DONE until start deasserts or reset.
REQ-028 SHALL run a 16-bit timeout counter that clears on every state entry and increments in WAIT_x and PATTERN states; reaching TIMEOUT_CYCLES forces ERROR on the next cycle.
REQ-029 SHALL, in ERROR, set o_train_error=1 with all other outputs 0 except o_lane_reversal, which holds its value.
REQ-030 SHALL give i_falling_edge_busy, i_msg_valid and i_pattern_done no effect outside their consuming states.
REQ-031 SHALL resolve simultaneous events as follows:
- Timeout and the expected response in the same cycle: the response wins.
- Expected response and i_falling_edge_busy in the same cycle: only the current state's event is used.
REQ-032 SHALL, on i_MBINIT_REPAIRCLK_end=0 in any non-IDLE state, return to IDLE next cycle and clear all outputs, including o_lane_reversal and o_train_error.

Reset
REQ-033 SHALL, on rst_n=0 at a clock edge, enter IDLE with all outputs 0, the timeout counter 0 and the result register 0, regardless of current state.
REQ-034 SHALL, while rst_n=0, ignore all inputs.

Verification
REQ-035 SHALL cover the nominal case:
- Stimulus: start=1; ack each request; results 16'hFFFF.
- Response: message sequence 1,3,5,7; o_MBINIT_REVERSALMB_end=1; o_lane_reversal=0.
REQ-036 SHALL cover the reversal retry:
- Stimulus: first results 16'h00FF (popcount 8, FAIL), second 16'hFF7F (15).
- Response: o_lane_reversal=1; second CLR_REQ sent; end=1.
REQ-037 SHALL cover the double failure:
- Stimulus: results 16'h0001 twice.
- Response: ERROR; o_train_error=1; end=0; o_lane_reversal=1.
REQ-038 SHALL cover the timeout:
- Stimulus: no INIT_RESP for TIMEOUT_CYCLES cycles.
- Response: o_train_error=1 on the following cycle.
- Stimulus: INIT_RESP on the exact timeout cycle.
- Response: proceeds to SEND_CLR.
REQ-039 SHALL cover ignored messages:
- Stimulus: in WAIT_CLR, i_msg_valid with code 6.
- Response: state unchanged; a later code 4 advances to PATTERN.
REQ-040 SHALL cover mid-operation abort:
- Stimulus: rst_n=0 during PATTERN, or start=0 during WAIT_RES.
- Response: outputs 0 next cycle; restart runs the full sequence from INIT_REQ.
